// File: rtl/block_header_parser.sv
// ============================================================================
// block_header_parser : Zstd block header decoder and block byte emitter
// Rev 1.0
// ============================================================================
`default_nettype none

module block_header_parser #(
  parameter int MAX_BLOCK_SIZE = 131072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        have_extra,
  input  logic [7:0]  extra_byte,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_compressed,
  output logic        hdr_valid,
  output logic        last_block,
  output logic [1:0]  block_type,
  output logic [20:0] block_size,
  output logic        frame_done,
  output logic        error,
  output logic        leftover_valid,
  output logic [7:0]  leftover_byte
);

  localparam logic [3:0] C_IDLE      = 4'd0;
  localparam logic [3:0] C_HDR0      = 4'd1;
  localparam logic [3:0] C_HDR1      = 4'd2;
  localparam logic [3:0] C_HDR2      = 4'd3;
  localparam logic [3:0] C_CHECK     = 4'd4;
  localparam logic [3:0] C_COPY      = 4'd5;
  localparam logic [3:0] C_RLE_FETCH = 4'd6;
  localparam logic [3:0] C_RLE_EMIT  = 4'd7;
  localparam logic [3:0] C_DONE      = 4'd8;
  localparam logic [3:0] C_ERR       = 4'd9;

  localparam logic [20:0] C_MAX_SIZE = 21'(MAX_BLOCK_SIZE);

  logic [3:0]  r_state;
  logic [1:0]  r_count;
  logic [7:0]  r_buf0;
  logic [7:0]  r_buf1;
  logic [7:0]  r_hdr0;
  logic [7:0]  r_hdr1;
  logic [7:0]  r_rle;
  logic [20:0] r_remaining;
  logic        r_last;
  logic [1:0]  r_type;
  logic [20:0] r_size;

  logic w_busy;
  logic w_have_byte;
  logic w_take_word;
  logic w_out_fire;
  logic w_byte_state;
  logic w_consume;
  logic w_start_ok;

  assign w_busy       = (r_state != C_IDLE) && (r_state != C_DONE) && (r_state != C_ERR);
  assign w_have_byte  = (r_count != 2'd0);
  assign data_ready   = (r_count == 2'd0) && w_busy;
  assign w_take_word  = data_valid && data_ready;
  assign w_start_ok   = start && ((r_state == C_IDLE) || (r_state == C_DONE));

  assign out_valid = ((r_state == C_COPY) && w_have_byte && (r_remaining != 21'd0)) ||
                     ((r_state == C_RLE_EMIT) && (r_remaining != 21'd0));
  assign out_byte  = (r_state == C_COPY)     ? r_buf0 :
                     (r_state == C_RLE_EMIT) ? r_rle  : 8'd0;
  assign w_out_fire = out_valid && out_ready;

  // Header bytes and the RLE symbol are pulled one per cycle; COPY pulls on handshake
  assign w_byte_state = (r_state == C_HDR0) || (r_state == C_HDR1) ||
                        (r_state == C_HDR2) || (r_state == C_RLE_FETCH);
  assign w_consume    = (w_byte_state && w_have_byte) ||
                        ((r_state == C_COPY) && w_out_fire);

  assign out_compressed = (r_state == C_COPY) && (r_type == 2'd2);
  assign hdr_valid      = (r_state == C_CHECK);
  assign last_block     = r_last;
  assign block_type     = r_type;
  assign block_size     = r_size;
  assign frame_done     = (r_state == C_DONE);
  assign error          = (r_state == C_ERR);
  assign leftover_valid = (r_state == C_DONE) && (r_count == 2'd1);
  assign leftover_byte  = leftover_valid ? r_buf0 : 8'd0;

  // Byte buffer: a word is only accepted when empty, so load and consume never collide
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 2'd0;
      r_buf0  <= 8'd0;
      r_buf1  <= 8'd0;
    end else if (w_start_ok) begin
      r_count <= have_extra ? 2'd1 : 2'd0;
      r_buf0  <= extra_byte;
    end else if (w_take_word) begin
      r_count <= 2'd2;
      r_buf0  <= data_in[7:0];
      r_buf1  <= data_in[15:8];
    end else if (w_consume) begin
      r_count <= r_count - 2'd1;
      r_buf0  <= r_buf1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= C_IDLE;
      r_hdr0      <= 8'd0;
      r_hdr1      <= 8'd0;
      r_rle       <= 8'd0;
      r_remaining <= 21'd0;
      r_last      <= 1'b0;
      r_type      <= 2'd0;
      r_size      <= 21'd0;
    end else begin
      case (r_state)
        C_IDLE, C_DONE: begin
          if (w_start_ok) r_state <= C_HDR0;
        end
        C_HDR0: begin
          if (w_have_byte) begin
            r_hdr0  <= r_buf0;
            r_state <= C_HDR1;
          end
        end
        C_HDR1: begin
          if (w_have_byte) begin
            r_hdr1  <= r_buf0;
            r_state <= C_HDR2;
          end
        end
        C_HDR2: begin
          if (w_have_byte) begin
            r_last  <= r_hdr0[0];
            r_type  <= r_hdr0[2:1];
            r_size  <= {r_buf0, r_hdr1, r_hdr0[7:3]};
            r_state <= C_CHECK;
          end
        end
        C_CHECK: begin
          r_remaining <= r_size;
          if ((r_type == 2'd3) || (r_size > C_MAX_SIZE)) r_state <= C_ERR;
          else if (r_type == 2'd1)                       r_state <= C_RLE_FETCH;
          else                                           r_state <= C_COPY;
        end
        C_RLE_FETCH: begin
          if (w_have_byte) begin
            r_rle   <= r_buf0;
            r_state <= C_RLE_EMIT;
          end
        end
        C_COPY, C_RLE_EMIT: begin
          if (r_remaining == 21'd0)  r_state <= r_last ? C_DONE : C_HDR0;
          else if (w_out_fire)       r_remaining <= r_remaining - 21'd1;
        end
        C_ERR: r_state <= C_ERR;
        default: r_state <= C_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
